// File: rtl/la_cmd_pkg.sv
// ---------------------------------------------------------------------------
// la_cmd_pkg
// Shared definitions for the logic-analyser command path: opcode bytes,
// argument counts and decoder FSM state encodings. The TX controller imports
// this too, so it can recognise the '?' status opcode.
// ---------------------------------------------------------------------------
package la_cmd_pkg;

    localparam logic [7:0] OP_MASK = 8'h4D;  // 'M' : 1 arg, trigger mask
    localparam logic [7:0] OP_DIV  = 8'h44;  // 'D' : 2 args, sample divider
    localparam logic [7:0] OP_ARM  = 8'h41;  // 'A' : arm capture
    localparam logic [7:0] OP_RST  = 8'h52;  // 'R' : soft reset
    localparam logic [7:0] OP_STAT = 8'h3F;  // '?' : status report

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CMD_UNLOAD = 3'd1,
        ST_ARG_WAIT   = 3'd2,
        ST_ARG_UNLOAD = 3'd3,
        ST_EXEC       = 3'd4,
        ST_ERROR      = 3'd5
    } dec_state_t;

    function automatic logic op_known(input logic [7:0] op);
        return (op == OP_MASK) || (op == OP_DIV) || (op == OP_ARM) ||
               (op == OP_RST)  || (op == OP_STAT);
    endfunction

    function automatic logic [1:0] op_nargs(input logic [7:0] op);
        case (op)
            OP_MASK: return 2'd1;
            OP_DIV:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/uart_cmd_decoder_if.sv
// ---------------------------------------------------------------------------
// uart_cmd_decoder_if
// Byte handshake between a UART receiver and the command decoder.
//   uart_rxdata      : received byte, valid while uart_rxempty = 0
//   uart_rxempty     : RX buffer holds no byte
//   uart_rx_enable   : receiver enable from the decoder
//   uart_uld_rx_data : one-cycle unload (pop) strobe from the decoder
// master = decoder side, slave = UART side.
// ---------------------------------------------------------------------------
interface uart_cmd_decoder_if;
    logic [7:0] uart_rxdata;
    logic       uart_rxempty;
    logic       uart_rx_enable;
    logic       uart_uld_rx_data;

    modport master (
        input  uart_rxdata,
        input  uart_rxempty,
        output uart_rx_enable,
        output uart_uld_rx_data
    );

    modport slave (
        output uart_rxdata,
        output uart_rxempty,
        input  uart_rx_enable,
        input  uart_uld_rx_data
    );
endinterface

// File: rtl/uart_cmd_decoder.sv
// ---------------------------------------------------------------------------
// uart_cmd_decoder
// Pulls command frames (opcode + 0..2 argument bytes, MSB first) out of a
// UART receiver and turns them into configuration registers and one-cycle
// control pulses. Bad opcodes, zero dividers and stalled frames are counted.
//   clk, rst          : clock, synchronous active-high reset
//   bus               : UART RX handshake (master side)
//   o_trig_mask       : trigger input mask
//   o_sample_div      : sample clock divider
//   o_arm_pulse       : capture arm request (1 cycle)
//   o_soft_rst_pulse  : trigger/FIFO reset request (1 cycle)
//   o_status_req      : status report request (1 cycle)
//   o_cmd_err_cnt     : rejected frame count, saturating
//   o_busy            : FSM not in IDLE
//   o_state_debug     : current FSM state encoding
// ---------------------------------------------------------------------------
module uart_cmd_decoder
    import la_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter logic [2:0]  MASK_RST       = 3'b111,
    parameter logic [15:0] DIV_RST        = 16'd1
) (
    input  logic                clk,
    input  logic                rst,
    uart_cmd_decoder_if.master  bus,
    output logic [2:0]          o_trig_mask,
    output logic [15:0]         o_sample_div,
    output logic                o_arm_pulse,
    output logic                o_soft_rst_pulse,
    output logic                o_status_req,
    output logic [7:0]          o_cmd_err_cnt,
    output logic                o_busy,
    output logic [2:0]          o_state_debug
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    dec_state_t  r_state, w_next;
    logic [7:0]  r_opcode;
    logic [1:0]  r_args_left;
    logic [15:0] r_shadow;
    logic [TW-1:0] r_timeout;
    logic [2:0]  r_trig_mask;
    logic [15:0] r_sample_div;
    logic [7:0]  r_err_cnt;
    logic        r_rx_en;
    logic        w_uld;
    logic        w_to_hit;
    logic [15:0] w_shadow_next;

    assign w_shadow_next = {r_shadow[7:0], bus.uart_rxdata};
    assign w_to_hit      = (r_timeout == TW'(TIMEOUT_CYCLES));

    // Unload states always last exactly one cycle and are never followed by
    // another unload state, so the UART has popped the byte before the FSM
    // next looks at uart_rxempty.
    always_comb begin
        w_next = r_state;
        w_uld  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!bus.uart_rxempty) w_next = ST_CMD_UNLOAD;
            end
            ST_CMD_UNLOAD: begin
                w_uld = 1'b1;
                if (!op_known(bus.uart_rxdata))              w_next = ST_ERROR;
                else if (op_nargs(bus.uart_rxdata) == 2'd0)  w_next = ST_EXEC;
                else                                         w_next = ST_ARG_WAIT;
            end
            ST_ARG_WAIT: begin
                if (w_to_hit)               w_next = ST_ERROR;
                else if (!bus.uart_rxempty) w_next = ST_ARG_UNLOAD;
            end
            ST_ARG_UNLOAD: begin
                w_uld = 1'b1;
                if (r_args_left == 2'd1) begin
                    // A zero divider is rejected before it can reach EXEC.
                    if (r_opcode == OP_DIV && w_shadow_next == 16'd0) w_next = ST_ERROR;
                    else                                             w_next = ST_EXEC;
                end else begin
                    w_next = ST_ARG_WAIT;
                end
            end
            ST_EXEC:  w_next = ST_IDLE;
            ST_ERROR: w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_opcode     <= 8'd0;
            r_args_left  <= 2'd0;
            r_shadow     <= 16'd0;
            r_timeout    <= '0;
            r_trig_mask  <= MASK_RST;
            r_sample_div <= DIV_RST;
            r_err_cnt    <= 8'd0;
            r_rx_en      <= 1'b0;
        end else begin
            r_state <= w_next;
            r_rx_en <= 1'b1;

            if (w_uld)                                     r_timeout <= '0;
            else if (r_state == ST_ARG_WAIT && !w_to_hit)  r_timeout <= r_timeout + 1'b1;

            case (r_state)
                ST_CMD_UNLOAD: begin
                    r_opcode    <= bus.uart_rxdata;
                    r_args_left <= op_nargs(bus.uart_rxdata);
                    r_shadow    <= 16'd0;
                end
                ST_ARG_UNLOAD: begin
                    r_shadow    <= w_shadow_next;
                    r_args_left <= r_args_left - 2'd1;
                end
                ST_EXEC: begin
                    if (r_opcode == OP_MASK) r_trig_mask  <= r_shadow[2:0];
                    if (r_opcode == OP_DIV)  r_sample_div <= r_shadow;
                end
                ST_ERROR: begin
                    if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.uart_uld_rx_data = w_uld;
    assign bus.uart_rx_enable   = r_rx_en;

    assign o_trig_mask      = r_trig_mask;
    assign o_sample_div     = r_sample_div;
    assign o_arm_pulse      = (r_state == ST_EXEC) && (r_opcode == OP_ARM);
    assign o_soft_rst_pulse = (r_state == ST_EXEC) && (r_opcode == OP_RST);
    assign o_status_req     = (r_state == ST_EXEC) && (r_opcode == OP_STAT);
    assign o_cmd_err_cnt    = r_err_cnt;
    assign o_busy           = (r_state != ST_IDLE);
    assign o_state_debug    = r_state;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_decoder
// Byte-queue UART model feeding the decoder; every observable output event
// (pulse, register change, error count change) is matched in order against
// an expected-event queue filled when each frame is queued.
// ---------------------------------------------------------------------------
module tb_uart_cmd_decoder;
    import la_cmd_pkg::*;

    localparam int          TO       = 50;
    localparam logic [2:0]  MASK_RST = 3'b111;
    localparam logic [15:0] DIV_RST  = 16'd1;

    localparam logic [3:0] EV_ARM = 4'd1, EV_SRST = 4'd2, EV_STAT = 4'd3,
                           EV_MASK = 4'd4, EV_DIV = 4'd5, EV_ERR = 4'd6;

    typedef struct packed {
        logic [3:0]  kind;
        logic [15:0] val;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  trig_mask;
    logic [15:0] sample_div;
    logic        arm_pulse, soft_rst_pulse, status_req, busy;
    logic [7:0]  err_cnt;
    logic [2:0]  state_dbg;

    uart_cmd_decoder_if u();

    uart_cmd_decoder #(
        .TIMEOUT_CYCLES (TO),
        .MASK_RST       (MASK_RST),
        .DIV_RST        (DIV_RST)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (u),
        .o_trig_mask      (trig_mask),
        .o_sample_div     (sample_div),
        .o_arm_pulse      (arm_pulse),
        .o_soft_rst_pulse (soft_rst_pulse),
        .o_status_req     (status_req),
        .o_cmd_err_cnt    (err_cnt),
        .o_busy           (busy),
        .o_state_debug    (state_dbg)
    );

    always #5 clk = ~clk;

    logic [7:0] rx_q[$];
    ev_t        exp_q[$];
    int         n_chk = 0, n_err = 0, n_uld = 0;
    logic       pend_pop = 1'b0;
    bit         mon_en = 1'b0;
    logic [2:0]  m_mask, p_mask;
    logic [15:0] m_div,  p_div;
    logic [7:0]  m_err,  p_err;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic expect_ev(input logic [3:0] k, input logic [15:0] v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic got(input string tag, input logic [3:0] k, input logic [15:0] v);
        ev_t e;
        chk({"sb_pending_", tag}, (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({"ev_", tag}, {12'd0, k, v}, {12'd0, e});
        end
    endtask

    // UART model: pops on the edge that samples the unload strobe.
    initial begin
        u.uart_rxdata  = 8'd0;
        u.uart_rxempty = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (pend_pop && rx_q.size() > 0) rx_q.delete(0);
            pend_pop       = 1'b0;
            u.uart_rxempty = (rx_q.size() == 0);
            u.uart_rxdata  = (rx_q.size() > 0) ? rx_q[0] : 8'd0;
        end
    end

    // Output monitor feeding the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            pend_pop = u.uart_uld_rx_data;
            if (u.uart_uld_rx_data) n_uld++;
            if (mon_en) begin
                if (arm_pulse)            got("arm",  EV_ARM,  16'd0);
                if (soft_rst_pulse)       got("srst", EV_SRST, 16'd0);
                if (status_req)           got("stat", EV_STAT, 16'd0);
                if (trig_mask !== p_mask) got("mask", EV_MASK, {13'd0, trig_mask});
                if (sample_div !== p_div) got("div",  EV_DIV,  sample_div);
                if (err_cnt !== p_err)    got("err",  EV_ERR,  {8'd0, err_cnt});
            end
            p_mask = trig_mask;
            p_div  = sample_div;
            p_err  = err_cnt;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog act=%0d exp=0", n_chk);
        $fatal(1, "watchdog");
    end

    task automatic exp_errinc();
        if (m_err != 8'hFF) begin
            m_err++;
            expect_ev(EV_ERR, {8'd0, m_err});
        end
    endtask

    task automatic frame_m(input logic [7:0] arg);
        if (m_mask != arg[2:0]) begin
            m_mask = arg[2:0];
            expect_ev(EV_MASK, {13'd0, m_mask});
        end
        rx_q.push_back(OP_MASK);
        rx_q.push_back(arg);
    endtask

    task automatic frame_d(input logic [7:0] hi, input logic [7:0] lo);
        if ({hi, lo} == 16'd0) exp_errinc();
        else if ({hi, lo} != m_div) begin
            m_div = {hi, lo};
            expect_ev(EV_DIV, m_div);
        end
        rx_q.push_back(OP_DIV);
        rx_q.push_back(hi);
        rx_q.push_back(lo);
    endtask

    task automatic frame0(input logic [7:0] op);
        case (op)
            OP_ARM:  expect_ev(EV_ARM,  16'd0);
            OP_RST:  expect_ev(EV_SRST, 16'd0);
            OP_STAT: expect_ev(EV_STAT, 16'd0);
            default: exp_errinc();
        endcase
        rx_q.push_back(op);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((rx_q.size() != 0 || busy) && n < budget);
        repeat (3) @(negedge clk);
        chk({"done_", tag}, (n < budget) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_mask"},  {29'd0, trig_mask}, {29'd0, MASK_RST});
        chk({tag, "_div"},   {16'd0, sample_div}, {16'd0, DIV_RST});
        chk({tag, "_err"},   {24'd0, err_cnt}, 32'd0);
        chk({tag, "_state"}, {29'd0, state_dbg}, {29'd0, ST_IDLE});
        chk({tag, "_ctl"},   {26'd0, busy, u.uart_rx_enable, u.uart_uld_rx_data,
                              arm_pulse, soft_rst_pulse, status_req}, 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset("rst0");
        rst = 1'b0;
        m_mask = MASK_RST; m_div = DIV_RST; m_err = 8'd0;
        @(negedge clk);
        chk("rx_en", {31'd0, u.uart_rx_enable}, 32'd1);
        mon_en = 1'b1;

        n_uld = 0;
        frame_m(8'h05);
        wait_idle(100, "m");
        chk("m_uld",  n_uld, 32'd2);
        chk("m_mask", {29'd0, trig_mask}, 32'd5);
        chk("m_err",  {24'd0, err_cnt}, 32'd0);

        frame_d(8'h01, 8'h2C);
        wait_idle(100, "d");
        chk("d_div", {16'd0, sample_div}, 32'h012C);

        frame_d(8'h00, 8'h00);
        wait_idle(100, "d0");
        chk("d0_div", {16'd0, sample_div}, 32'h012C);
        chk("d0_err", {24'd0, err_cnt}, 32'd1);

        frame0(OP_ARM);  wait_idle(100, "arm");
        frame0(OP_RST);  wait_idle(100, "srst");
        frame0(OP_STAT); wait_idle(100, "stat");

        // Back-to-back frames: bytes wait in the UART through EXEC/ERROR.
        frame0(OP_ARM);
        frame0(8'h7A);
        frame_m(8'h02);
        frame0(OP_STAT);
        frame_d(8'hBE, 8'hEF);
        wait_idle(200, "b2b");
        chk("b2b_mask", {29'd0, trig_mask}, 32'd2);
        chk("b2b_div",  {16'd0, sample_div}, 32'hBEEF);
        chk("b2b_err",  {24'd0, err_cnt}, 32'd2);

        // Stalled frame: opcode with its argument never arriving.
        exp_errinc();
        rx_q.push_back(OP_MASK);
        repeat (40) @(negedge clk);
        chk("to_early", {29'd0, state_dbg}, {29'd0, ST_ARG_WAIT});
        wait_idle(200, "to");
        chk("to_mask", {29'd0, trig_mask}, 32'd2);
        chk("to_err",  {24'd0, err_cnt}, 32'd3);
        frame0(OP_ARM);
        wait_idle(100, "to_arm");

        for (int i = 0; i < 300; i++) frame0(8'h7A);
        wait_idle(3000, "sat");
        chk("sat_err", {24'd0, err_cnt}, 32'hFF);

        // Reset between a 'D' opcode and its first argument.
        rx_q.push_back(OP_DIV);
        n = 0;
        while (state_dbg != ST_ARG_WAIT && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("mid_reach", {29'd0, state_dbg}, {29'd0, ST_ARG_WAIT});
        chk("sb_drain", exp_q.size(), 32'd0);
        mon_en = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset("rst1");
        rst = 1'b0;
        m_mask = MASK_RST; m_div = DIV_RST; m_err = 8'd0;
        mon_en = 1'b1;
        frame0(OP_ARM);
        wait_idle(100, "post_rst");
        chk("post_mask", {29'd0, trig_mask}, {29'd0, MASK_RST});
        chk("post_div",  {16'd0, sample_div}, {16'd0, DIV_RST});

        chk("sb_left", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
